// File: rtl/wb_stage_param_pkg.sv
// Shared definitions for the parametrised writeback stage.
// Provides MEM->WB bus field offsets, derived bus widths and exception codes.
// Latency/backpressure: n/a (types and constant functions only).
package wb_stage_param_pkg;

  typedef enum logic [5:0] {
    ECODE_ADEF = 6'h08,
    ECODE_ALE  = 6'h09,
    ECODE_SYS  = 6'h0B,
    ECODE_BRK  = 6'h0C,
    ECODE_INE  = 6'h0D
  } ecode_e;

  // MEM->WB bus layout, MSB->LSB: {gr_we, dest, result, pc, ex, ecode, ertn}
  function automatic int ms_bus_w(int data_w, int rf_aw, int ecode_w);
    return 1 + rf_aw + 2 * data_w + 1 + ecode_w + 1;
  endfunction

  function automatic int ws_rf_bus_w(int data_w, int rf_aw);
    return 1 + rf_aw + data_w;
  endfunction

  function automatic int ms_ertn_bit();
    return 0;
  endfunction

  function automatic int ms_ecode_lsb();
    return 1;
  endfunction

  function automatic int ms_ex_bit(int ecode_w);
    return 1 + ecode_w;
  endfunction

  function automatic int ms_pc_lsb(int ecode_w);
    return 2 + ecode_w;
  endfunction

  function automatic int ms_result_lsb(int data_w, int ecode_w);
    return 2 + ecode_w + data_w;
  endfunction

  function automatic int ms_dest_lsb(int data_w, int ecode_w);
    return 2 + ecode_w + 2 * data_w;
  endfunction

  function automatic int ms_gr_we_bit(int data_w, int rf_aw, int ecode_w);
    return 2 + ecode_w + 2 * data_w + rf_aw;
  endfunction

endpackage

// File: rtl/wb_stage_param_perf_counter.sv
// Free-running event counter: count_o advances by one on each cycle inc_i is high.
// Latency: increment visible the cycle after inc_i; wraps modulo 2^CNT_W.
// Backpressure: none; ports inc_i (event), count_o (current count), sync active-high reset.
module wb_stage_param_perf_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/wb_stage_param.sv
// Writeback stage: latches MEM->WB bus, commits RF writes, hands exceptions/ERTN to CSR.
// Latency: one cycle per instruction; special instructions hold until csr_ack.
// Backpressure: ws_allowin drops while a special instruction waits for csr_ack.
// Ports: MEM handshake (ms_to_ws_*/ws_allowin), RF write bus, CSR req/ack + wb_flush,
// forwarding (ws_fwd_*), retire_cnt, debug trace (debug_wb_*).
module wb_stage_param
  import wb_stage_param_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RF_AW    = 5,
  parameter int ECODE_W  = 6,
  parameter int CNT_W    = 64,
  parameter int MS_BUS_W = ms_bus_w(DATA_W, RF_AW, ECODE_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   ws_allowin,
  input  logic                   ms_to_ws_valid,
  input  logic [MS_BUS_W-1:0]    ms_to_ws_bus,
  output logic [ws_rf_bus_w(DATA_W, RF_AW)-1:0] ws_to_rf_bus,
  output logic                   csr_req,
  output logic                   csr_ex,
  output logic [ECODE_W-1:0]     csr_ecode,
  output logic [DATA_W-1:0]      csr_epc,
  input  logic                   csr_ack,
  output logic                   wb_flush,
  output logic                   ws_fwd_valid,
  output logic [RF_AW-1:0]       ws_fwd_dest,
  output logic [DATA_W-1:0]      ws_fwd_value,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [DATA_W-1:0]      debug_wb_pc,
  output logic [3:0]             debug_wb_rf_wen,
  output logic [RF_AW-1:0]       debug_wb_rf_wnum,
  output logic [DATA_W-1:0]      debug_wb_rf_wdata
);

  localparam int ERTN_BIT   = ms_ertn_bit();
  localparam int ECODE_LSB  = ms_ecode_lsb();
  localparam int EX_BIT     = ms_ex_bit(ECODE_W);
  localparam int PC_LSB     = ms_pc_lsb(ECODE_W);
  localparam int RESULT_LSB = ms_result_lsb(DATA_W, ECODE_W);
  localparam int DEST_LSB   = ms_dest_lsb(DATA_W, ECODE_W);
  localparam int GR_WE_BIT  = ms_gr_we_bit(DATA_W, RF_AW, ECODE_W);

  logic                ws_valid_q, ws_valid_d;
  logic [MS_BUS_W-1:0] bus_q, bus_d;

  logic                gr_we, ex, ertn;
  logic [RF_AW-1:0]    dest;
  logic [DATA_W-1:0]   result, pc;
  logic [ECODE_W-1:0]  ecode;
  logic                ws_special, ws_ready_go, rf_we, retire_inc;

  assign gr_we  = bus_q[GR_WE_BIT];
  assign dest   = bus_q[DEST_LSB +: RF_AW];
  assign result = bus_q[RESULT_LSB +: DATA_W];
  assign pc     = bus_q[PC_LSB +: DATA_W];
  assign ex     = bus_q[EX_BIT];
  assign ecode  = bus_q[ECODE_LSB +: ECODE_W];
  assign ertn   = bus_q[ERTN_BIT];

  assign ws_special  = ws_valid_q & (ex | ertn);
  assign ws_ready_go = ~ws_special | csr_ack;
  assign ws_allowin  = ~ws_valid_q | ws_ready_go;
  assign wb_flush    = ws_special & csr_ack;

  // A faulting instruction never writes the RF; ERTN with gr_we does.
  assign rf_we       = ws_valid_q & gr_we & ~ex;
  assign retire_inc  = ws_valid_q & ws_ready_go & ~ex;

  always_comb begin
    ws_valid_d = ws_valid_q;
    bus_d      = bus_q;
    // The flush cycle's incoming instruction is younger than the special one, so it dies.
    if (wb_flush)        ws_valid_d = 1'b0;
    else if (ws_allowin) ws_valid_d = ms_to_ws_valid;
    if (ms_to_ws_valid && ws_allowin && !wb_flush) bus_d = ms_to_ws_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      bus_q      <= bus_d;
    end
  end

  wb_stage_param_perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (retire_inc),
    .count_o (retire_cnt)
  );

  assign ws_to_rf_bus = {rf_we, dest, result};

  assign csr_req   = ws_special;
  assign csr_ex    = ex;
  assign csr_ecode = ecode;
  assign csr_epc   = pc;

  assign ws_fwd_valid = rf_we;
  assign ws_fwd_dest  = rf_we ? dest   : '0;
  assign ws_fwd_value = rf_we ? result : '0;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = dest;
  assign debug_wb_rf_wdata = result;

endmodule

// File: tb/tb_wb_stage_param.sv
module tb_wb_stage_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = 6;
  localparam int CW = 4;
  localparam int BW = 1 + AW + 2*DW + 1 + EW + 1;
  localparam int RW = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ws_allowin;
  logic          ms_to_ws_valid = 1'b0;
  logic [BW-1:0] ms_to_ws_bus = '0;
  logic [RW-1:0] ws_to_rf_bus;
  logic          csr_req, csr_ex;
  logic [EW-1:0] csr_ecode;
  logic [DW-1:0] csr_epc;
  logic          csr_ack = 1'b0;
  logic          wb_flush;
  logic          ws_fwd_valid;
  logic [AW-1:0] ws_fwd_dest;
  logic [DW-1:0] ws_fwd_value;
  logic [CW-1:0] retire_cnt;
  logic [DW-1:0] debug_wb_pc;
  logic [3:0]    debug_wb_rf_wen;
  logic [AW-1:0] debug_wb_rf_wnum;
  logic [DW-1:0] debug_wb_rf_wdata;

  wb_stage_param #(.DATA_W(DW), .RF_AW(AW), .ECODE_W(EW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_to_rf_bus(ws_to_rf_bus), .csr_req(csr_req), .csr_ex(csr_ex),
    .csr_ecode(csr_ecode), .csr_epc(csr_epc), .csr_ack(csr_ack),
    .wb_flush(wb_flush), .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest),
    .ws_fwd_value(ws_fwd_value), .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } rf_exp_t;
  typedef struct { logic ex; logic [EW-1:0] ecode; logic [DW-1:0] epc; } csr_exp_t;
  rf_exp_t  rf_q[$];
  csr_exp_t csr_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk_bus(input logic gr_we, input logic [AW-1:0] dest,
                                           input logic [DW-1:0] res, input logic [DW-1:0] pc,
                                           input logic ex, input logic [EW-1:0] ecode,
                                           input logic ertn);
    return {gr_we, dest, res, pc, ex, ecode, ertn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [BW-1:0] b);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = b;
    step();
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic push_rf(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rf_exp_t e;
    e.addr = a; e.data = d;
    rf_q.push_back(e);
  endtask

  task automatic push_csr(input logic ex, input logic [EW-1:0] ec, input logic [DW-1:0] epc);
    csr_exp_t e;
    e.ex = ex; e.ecode = ec; e.epc = epc;
    csr_q.push_back(e);
  endtask

  // Monitor: an RF write commits when rf_we and the stage can advance; a flush ends a CSR request.
  always @(negedge clk) begin
    if (!reset) begin
      chk("debug_wen_vs_rf_we", {60'd0, debug_wb_rf_wen}, {60'd0, {4{ws_to_rf_bus[RW-1]}}});
      if (ws_to_rf_bus[RW-1] && ws_allowin) begin
        if (rf_q.size() == 0) begin
          chk("rf_unexpected_write", {58'd0, ws_to_rf_bus[RW-2 -: AW], 1'b1}, 64'd0);
        end else begin
          rf_exp_t e;
          e = rf_q.pop_front();
          chk("rf_waddr", {59'd0, ws_to_rf_bus[RW-2 -: AW]}, {59'd0, e.addr});
          chk("rf_wdata", {32'd0, ws_to_rf_bus[DW-1:0]}, {32'd0, e.data});
        end
      end
      if (wb_flush) begin
        if (csr_q.size() == 0) begin
          chk("unexpected_flush", 64'd1, 64'd0);
        end else begin
          csr_exp_t c;
          c = csr_q.pop_front();
          chk("csr_ex", {63'd0, csr_ex}, {63'd0, c.ex});
          chk("csr_ecode", {58'd0, csr_ecode}, {58'd0, c.ecode});
          chk("csr_epc", {32'd0, csr_epc}, {32'd0, c.epc});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_allowin"}, {63'd0, ws_allowin}, 64'd1);
    chk({tag, "_rf_bus"}, {26'd0, ws_to_rf_bus}, 64'd0);
    chk({tag, "_csr_req"}, {63'd0, csr_req}, 64'd0);
    chk({tag, "_flush"}, {63'd0, wb_flush}, 64'd0);
    chk({tag, "_fwd"}, {26'd0, ws_fwd_valid, ws_fwd_dest, ws_fwd_value}, 64'd0);
    chk({tag, "_retire"}, {60'd0, retire_cnt}, 64'd0);
    chk({tag, "_dbg_pc"}, {32'd0, debug_wb_pc}, 64'd0);
    chk({tag, "_dbg_wen"}, {60'd0, debug_wb_rf_wen}, 64'd0);
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    chk_idle_outputs("reset");

    // Back-to-back normal writes
    push_rf(5'd3, 32'h11); issue(mk_bus(1'b1, 5'd3, 32'h11, 32'h1C00_0000, 1'b0, 6'h0, 1'b0));
    chk("b2b_allowin1", {63'd0, ws_allowin}, 64'd1);
    push_rf(5'd4, 32'h22); issue(mk_bus(1'b1, 5'd4, 32'h22, 32'h1C00_0004, 1'b0, 6'h0, 1'b0));
    chk("b2b_allowin2", {63'd0, ws_allowin}, 64'd1);
    push_rf(5'd5, 32'h33); issue(mk_bus(1'b1, 5'd5, 32'h33, 32'h1C00_0008, 1'b0, 6'h0, 1'b0));
    chk("b2b_allowin3", {63'd0, ws_allowin}, 64'd1);
    step();
    chk("b2b_retire", {60'd0, retire_cnt}, 64'd3);

    // Exception with ack three cycles after it arrives; a younger instruction arrives in the ack cycle
    push_csr(1'b1, 6'h0B, 32'h1C00_0010);
    issue(mk_bus(1'b1, 5'd9, 32'h99, 32'h1C00_0010, 1'b1, 6'h0B, 1'b0));
    for (int i = 0; i < 4; i++) begin
      chk("exc_csr_req", {63'd0, csr_req}, 64'd1);
      chk("exc_allowin", {63'd0, ws_allowin}, 64'd0);
      chk("exc_rf_we", {63'd0, ws_to_rf_bus[RW-1]}, 64'd0);
      chk("exc_flush_early", {63'd0, wb_flush}, 64'd0);
      if (i < 3) step();
    end
    csr_ack = 1'b1;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus = mk_bus(1'b1, 5'd10, 32'hAA, 32'h1C00_0014, 1'b0, 6'h0, 1'b0);
    #1;
    chk("exc_flush", {63'd0, wb_flush}, 64'd1);
    chk("exc_allowin_ack", {63'd0, ws_allowin}, 64'd1);
    step();
    csr_ack = 1'b0;
    ms_to_ws_valid = 1'b0;
    chk("flush_drop_req", {63'd0, csr_req}, 64'd0);
    chk("flush_drop_rf_we", {63'd0, ws_to_rf_bus[RW-1]}, 64'd0);
    chk("flush_drop_flush", {63'd0, wb_flush}, 64'd0);
    chk("exc_retire", {60'd0, retire_cnt}, 64'd3);

    // ERTN (with gr_we) acknowledged in its first WB cycle
    push_rf(5'd6, 32'h66);
    push_csr(1'b0, 6'h0, 32'h1C00_0020);
    issue(mk_bus(1'b1, 5'd6, 32'h66, 32'h1C00_0020, 1'b0, 6'h0, 1'b1));
    chk("ertn_req", {63'd0, csr_req}, 64'd1);
    chk("ertn_ex", {63'd0, csr_ex}, 64'd0);
    csr_ack = 1'b1;
    #1;
    chk("ertn_flush", {63'd0, wb_flush}, 64'd1);
    step();
    csr_ack = 1'b0;
    chk("ertn_flush_off", {63'd0, wb_flush}, 64'd0);
    chk("ertn_retire", {60'd0, retire_cnt}, 64'd4);

    // Forwarding mask when no RF write
    issue(mk_bus(1'b0, 5'd7, 32'hDEAD, 32'h1C00_0030, 1'b0, 6'h0, 1'b0));
    chk("fwd_valid", {63'd0, ws_fwd_valid}, 64'd0);
    chk("fwd_dest", {59'd0, ws_fwd_dest}, 64'd0);
    chk("fwd_value", {32'd0, ws_fwd_value}, 64'd0);
    chk("dbg_wnum", {59'd0, debug_wb_rf_wnum}, 64'd7);
    chk("dbg_wdata", {32'd0, debug_wb_rf_wdata}, 64'hDEAD);
    chk("dbg_pc", {32'd0, debug_wb_pc}, 64'h1C00_0030);
    step();
    chk("fwd_retire", {60'd0, retire_cnt}, 64'd5);

    // Twelve more retirements: 17 total wraps a 4-bit counter to 1
    for (int i = 0; i < 12; i++) begin
      logic [AW-1:0] d;
      logic [DW-1:0] r;
      d = AW'(i + 11);
      r = 32'h100 + DW'(i);
      push_rf(d, r);
      issue(mk_bus(1'b1, d, r, 32'h1C00_0100 + DW'(4 * i), 1'b0, 6'h0, 1'b0));
      chk("wrap_fwd_value", {32'd0, ws_fwd_value}, {32'd0, r});
    end
    step();
    chk("wrap_retire", {60'd0, retire_cnt}, 64'd1);

    // Reset while a CSR request is pending
    issue(mk_bus(1'b1, 5'd8, 32'h88, 32'h1C00_0040, 1'b1, 6'h0D, 1'b0));
    chk("rst_pending_req", {63'd0, csr_req}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle_outputs("midrst");

    repeat (3) step();
    chk("rf_queue_drained", 64'(rf_q.size()), 64'd0);
    chk("csr_queue_drained", 64'(csr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage_param.md
Name: wb_stage_param

Overview:
Parametrised writeback stage, successor to the fixed 32-bit WB stage. Latches the MEM→WB bus under a valid/allowin handshake and commits register-file writes. Adds exception/ERTN commit with a CSR acknowledge handshake and a pipeline flush pulse. Also adds a forwarding port with an explicit valid bit, and a retired-instruction counter. Sits between the MEM stage and the register file/CSR unit.

Parameters:
DATA_W, 32, datapath and PC width
RF_AW, 5, register-file address width
ECODE_W, 6, exception code width
CNT_W, 64, retired-instruction counter width
MS_BUS_W, 1+RF_AW+2*DATA_W+1+ECODE_W+1, derived MEM→WB bus width; not to be overridden

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ws_allowin  out  1  WB can accept a new bus this cycle
ms_to_ws_valid  in  1  MEM holds a valid instruction
ms_to_ws_bus  in  MS_BUS_W  {gr_we, dest, result, pc, ex, ecode, ertn}, MSB→LSB
ws_to_rf_bus  out  1+RF_AW+DATA_W  {rf_we, rf_waddr, rf_wdata}
csr_req  out  1  exception/ERTN commit request to CSR
csr_ex  out  1  request is an exception (0 = ERTN)
csr_ecode  out  ECODE_W  exception code
csr_epc  out  DATA_W  PC of the faulting instruction
csr_ack  in  1  CSR accepted the request this cycle
wb_flush  out  1  one-cycle flush pulse to all earlier stages
ws_fwd_valid  out  1  forwarding data valid
ws_fwd_dest  out  RF_AW  forwarded destination
ws_fwd_value  out  DATA_W  forwarded value
retire_cnt  out  CNT_W  retired-instruction count
debug_wb_pc  out  DATA_W  trace PC
debug_wb_rf_wen  out  4  trace write enable (replicated rf_we)
debug_wb_rf_wnum  out  RF_AW  trace destination
debug_wb_rf_wdata  out  DATA_W  trace data

Behaviour:
- Reset (synchronous, active-high): ws_valid=0, bus register=0, retire_cnt=0. Consequently rf_we, csr_req, wb_flush, ws_fwd_valid and debug_wb_rf_wen are all 0, and the debug/fwd data outputs are 0.
- Special instruction: ws_special = ws_valid & (ex | ertn).
- ws_ready_go = !ws_special | csr_ack.
- ws_allowin = !ws_valid | ws_ready_go.
- Valid update, each cycle:
  - if wb_flush: ws_valid←0; any ms_to_ws_valid arriving in the same cycle is discarded, because it is younger.
  - else if ws_allowin: ws_valid←ms_to_ws_valid.
- Bus register loads when ms_to_ws_valid & ws_allowin & !wb_flush; otherwise it holds.
- rf_we = ws_valid & gr_we & !ex. A faulting instruction never writes the RF. An ERTN with gr_we set writes normally.
- CSR handshake:
  - csr_req = ws_special; it stays high, with stable csr_ex/ecode/epc, until csr_ack.
  - csr_ack while csr_req is low is ignored.
- wb_flush = ws_special & csr_ack. This is combinational, exactly one cycle per special instruction.
- Forwarding:
  - ws_fwd_valid = rf_we.
  - ws_fwd_dest and ws_fwd_value are masked to 0 when ws_fwd_valid = 0.
- Retired-instruction counter:
  - retire_cnt increments by 1 when ws_valid & ws_ready_go & !ex; an ERTN counts as retired.
  - It wraps modulo 2^CNT_W without saturation.
- Latency: an instruction accepted at edge N drives the RF write during cycle N+1. It commits in one cycle unless it is special, in which case it waits for csr_ack.
- Stall: while a special instruction waits, ws_allowin=0 and MEM must hold its bus.
- Reset mid-handshake: a pending csr_req drops the cycle after reset; no flush is generated.
- Debug outputs:
  - debug_wb_pc = pc.
  - debug_wb_rf_wen = {4{rf_we}}.
  - debug_wb_rf_wnum = dest.
  - debug_wb_rf_wdata = result.

Decomposition:
- Shared package:
  - bus field offsets / MS_BUS_W and WS_RF_BUS_W derivation functions;
  - ECODE constants (ADEF, SYS, BRK, INE, ALE).
- Sub-module perf_counter (width CNT_W, synchronous reset, inc input, count output); reused for future cycle counters.
- The rest of the stage is flat.

Test Plan:
- Back-to-back normal writes: three valid bus words with gr_we=1, dest=3/4/5, result=0x11/0x22/0x33 on consecutive cycles → rf_we high three cycles, waddr/wdata match, ws_allowin stays 1, retire_cnt=3.
- Exception with delayed ack: bus with ex=1, ecode=0x0B, pc=0x1C00_0010, gr_we=1; csr_ack asserted 3 cycles later:
  - csr_req high for 4 cycles, rf_we=0, ws_allowin=0 until ack;
  - wb_flush pulses exactly once;
  - retire_cnt unchanged.
- Flush drops younger instruction: ms_to_ws_valid=1 during the ack cycle → ws_valid=0 on the next cycle, no RF write for the younger instruction.
- ERTN with ack in the same cycle: csr_ex=0, wb_flush=1 for one cycle, retire_cnt increments by 1.
- Forwarding mask: gr_we=0, dest=7, result=0xDEAD → ws_fwd_valid=0, ws_fwd_dest=0, ws_fwd_value=0.
- Counter wrap and reset: with CNT_W=4, retire 17 instructions → retire_cnt=1. Assert reset while csr_req is pending → all outputs 0 the next cycle, no wb_flush.
